midi_message_parser: RTL
========================

// Module: midi_message_parser
// PURPOSE
//  Sequences the byte stream from midi_receiver (dout/valid) into complete MIDI channel messages.
//  Tracks status and running status, and counts data bytes per message type.
//  Emits one event per Note On/Off, Control Change or Pitch Bend through a 1-entry valid/ready output register.
//  Sits between midi_receiver and the synth voice allocator.
// PARAMETERS
//  OMNI     1  1: accept all channels; 0: accept only CHANNEL
//  CHANNEL  0  4-bit channel filter value; used only when OMNI=0
// PORTS
//  clk           in   1  system clock (50 MHz)
//  reset         in   1  one clock; reset is synchronous and active-low (reset==0 resets on posedge clk)
//  byte_in       in   8  received byte (midi_receiver dout)
//  byte_valid    in   1  1-cycle strobe: byte_in is valid
//  ev_valid      out  1  event register holds an event
//  ev_ready      in   1  consumer accepts the event when ev_valid && ev_ready
//  ev_type       out  2  midi_pkg::ev_t: NOTE_OFF=0, NOTE_ON=1, CC=2, PBEND=3
//  ev_channel    out  4  message channel (status low nibble)
//  ev_data1      out  7  note / controller number / pitch-bend LSB
//  ev_data2      out  7  velocity / controller value / pitch-bend MSB
//  ev_overflow   out  1  1-cycle pulse: completed event dropped because register was full
// BEHAVIOUR
//  Reset: state=NO_STATUS, running status cleared, ev_valid=0, ev_overflow=0.
//   ev_type, ev_channel, ev_data1, ev_data2 all reset to 0.
//  Bytes are processed only on cycles with byte_valid=1; all other cycles hold state.
//  Byte classes:
//   - 0xF8-0xFF real-time: ignored completely; state, counters and running status untouched.
//   - 0x80-0xEF channel status: latch status and channel; data count=0; go to WAIT_D1.
//   - 0xF0-0xF7 system status: clear running status; go to SKIP.
//   - 0x00-0x7F data: handled according to current state.
//  States:
//   NO_STATUS: data bytes dropped.
//   WAIT_D1: store data1.
//     Types Cn/Dn: message complete and discarded; stay in WAIT_D1 (running status).
//     Types 8n/9n/An/Bn/En: go to WAIT_D2.
//   WAIT_D2: store data2; message complete; return to WAIT_D1 (running status).
//   SKIP: data bytes dropped until the next channel status byte.
//  Completion of 8n/9n/Bn/En produces an event; An/Cn/Dn never produce one.
//  9n with data2==0 is reported as NOTE_OFF with ev_data2=0.
//  Channel filter: when OMNI=0 and channel!=CHANNEL, the message is parsed normally but no event is produced.
//  Latency: ev_valid rises the cycle after the byte_valid cycle that completes the message.
//  Output register rules:
//   - Loads when empty, or when ev_valid && ev_ready in the same cycle as a completion (ev_valid stays 1).
//   - Completion while ev_valid && !ev_ready: new event dropped, old event held, ev_overflow=1 for one cycle.
//   - ev_valid && ev_ready with no completion: ev_valid=0 next cycle.
//   - Fields are stable while ev_valid && !ev_ready.
//  Status byte arriving in WAIT_D2: partial message discarded; new status takes effect.
//  reset==0 mid-message or with an event pending: everything cleared, pending event lost, no overflow pulse.
// STRUCTURE
//  midi_pkg holds:
//   - ev_t enum and the parser state enum
//   - status nibble constants: NOTE_OFF=4'h8, NOTE_ON=4'h9, POLY_AT=4'hA, CC=4'hB, PROG=4'hC, CH_AT=4'hD, PBEND=4'hE
//   - REALTIME_MIN=8'hF8
//  Sub-module midi_event_reg: 1-entry valid/ready holding register with overflow pulse, parameterised on payload width.
//  Parser FSM and data-byte latches are implemented in this module.
// TESTING
//  90 3C 64 -> one event {NOTE_ON, ch0, 0x3C, 0x64} one cycle after the 0x64 strobe.
//  91 40 7F 40 00 (running status) -> {NOTE_ON, ch1, 0x40, 0x7F}, then {NOTE_OFF, ch1, 0x40, 0x00}.
//  90 3C F8 64 (real-time byte mid-message) -> single {NOTE_ON, ch0, 0x3C, 0x64}.
//  E2 00 40, then F0 01 02 F7 05 06 -> {PBEND, ch2, 0x00, 0x40}; no event for the SysEx or for 05 06.
//  C0 05 B3 07 64 -> no event for Cn; one {CC, ch3, 0x07, 0x64}.
//  Two Note On messages with ev_ready=0 -> first event held, ev_overflow pulses once.
//   Then ev_ready=1 -> the first event is consumed and ev_valid=0.
//  OMNI=0, CHANNEL=5: 94 3C 64 -> no event; 95 3C 64 -> {NOTE_ON, ch5, 0x3C, 0x64}.
//  reset=0 asserted after 90 3C -> after release, 64 alone -> no event.

Source files
------------

// File: rtl/midi_pkg.sv
// rtl/midi_pkg.sv - shared types and constants for the MIDI message parser
package midi_pkg;

  typedef enum logic [1:0] {
    EV_NOTE_OFF = 2'd0,
    EV_NOTE_ON  = 2'd1,
    EV_CC       = 2'd2,
    EV_PBEND    = 2'd3
  } ev_t;

  typedef enum logic [1:0] {
    NO_STATUS = 2'd0,
    WAIT_D1   = 2'd1,
    WAIT_D2   = 2'd2,
    SKIP      = 2'd3
  } parse_state_t;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CH_AT    = 4'hD;
  localparam logic [3:0] PBEND    = 4'hE;

  localparam logic [7:0] REALTIME_MIN = 8'hF8;

  // Event payload: {type[1:0], channel[3:0], data1[6:0], data2[6:0]}
  localparam int EV_W = 20;

  function automatic logic needs_two_data(input logic [3:0] status);
    return !((status == PROG) || (status == CH_AT));
  endfunction

  function automatic logic makes_event(input logic [3:0] status);
    return (status == NOTE_OFF) || (status == NOTE_ON) || (status == CC) || (status == PBEND);
  endfunction

endpackage

// File: rtl/midi_event_reg.sv
// rtl/midi_event_reg.sv - 1-entry valid/ready holding register with overflow pulse
module midi_event_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         load_valid_i,
  input  logic [W-1:0] load_data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         overflow_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         ovf_q, ovf_d;

  // A full register that is not being drained keeps its event; the newcomer is lost.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ovf_d   = 1'b0;
    if (load_valid_i && valid_q && !ready_i) begin
      ovf_d = 1'b1;
    end else if (load_valid_i) begin
      valid_d = 1'b1;
      data_d  = load_data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/midi_message_parser.sv
// rtl/midi_message_parser.sv - MIDI channel message parser with running status and event output
module midi_message_parser
  import midi_pkg::*;
#(
  parameter logic       OMNI    = 1'b1,
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [1:0] ev_type,
  output logic [3:0] ev_channel,
  output logic [6:0] ev_data1,
  output logic [6:0] ev_data2,
  output logic       ev_overflow
);

  parse_state_t state_q, state_d;
  logic [3:0]   status_q, status_d;
  logic [3:0]   chan_q, chan_d;
  logic [6:0]   d1_q, d1_d;
  logic         ev_load;
  ev_t          ev_kind;
  logic         chan_ok;
  logic [EV_W-1:0] ev_payload;
  logic [EV_W-1:0] ev_out;

  assign chan_ok = OMNI || (chan_q == CHANNEL);

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    chan_d   = chan_q;
    d1_d     = d1_q;
    ev_load  = 1'b0;
    if (byte_valid && (byte_in < REALTIME_MIN)) begin
      if (byte_in[7]) begin
        if (byte_in[7:4] == 4'hF) begin
          state_d  = SKIP;
          status_d = 4'h0;
        end else begin
          state_d  = WAIT_D1;
          status_d = byte_in[7:4];
          chan_d   = byte_in[3:0];
        end
      end else begin
        case (state_q)
          WAIT_D1: begin
            d1_d = byte_in[6:0];
            if (needs_two_data(status_q)) state_d = WAIT_D2;
          end
          WAIT_D2: begin
            state_d = WAIT_D1;
            ev_load = makes_event(status_q) && chan_ok;
          end
          default: ;
        endcase
      end
    end
  end

  // Zero-velocity Note On is reported as Note Off.
  always_comb begin
    ev_kind = EV_NOTE_OFF;
    case (status_q)
      NOTE_ON: ev_kind = (byte_in[6:0] == 7'd0) ? EV_NOTE_OFF : EV_NOTE_ON;
      CC:      ev_kind = EV_CC;
      PBEND:   ev_kind = EV_PBEND;
      default: ev_kind = EV_NOTE_OFF;
    endcase
  end

  assign ev_payload = {ev_kind, chan_q, d1_q, byte_in[6:0]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= NO_STATUS;
      status_q <= 4'h0;
      chan_q   <= 4'h0;
      d1_q     <= 7'd0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      chan_q   <= chan_d;
      d1_q     <= d1_d;
    end
  end

  midi_event_reg #(.W(EV_W)) u_event_reg (
    .clk_i        (clk),
    .reset_i      (reset),
    .load_valid_i (ev_load),
    .load_data_i  (ev_payload),
    .ready_i      (ev_ready),
    .valid_o      (ev_valid),
    .data_o       (ev_out),
    .overflow_o   (ev_overflow)
  );

  assign ev_type    = ev_out[19:18];
  assign ev_channel = ev_out[17:14];
  assign ev_data1   = ev_out[13:7];
  assign ev_data2   = ev_out[6:0];

endmodule
